// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word width and
// address-fault checks. Optional build macro: DMEM_RESPONDER_BYTE_EN.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / 8;
  localparam int CNT_W  = 4;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A fault is a misaligned byte address or a word index beyond the storage.
  function automatic logic addr_fault(input logic [WORD_W-1:0] addr,
                                      input logic [WORD_W-1:0] depth);
    logic [WORD_W-1:0] word_idx;
    word_idx = {2'b00, addr[WORD_W-1:2]};
    return ((addr[1:0] & ALIGN_MASK) != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor-side data-memory bus. Defining DMEM_RESPONDER_BYTE_EN adds the
// per-lane write enables i_be_w.
interface dmem_responder_if;

  logic                        i_req_w;
  logic                        i_we_w;
  logic [mips_pkg::WORD_W-1:0] i_a_w;
  logic [mips_pkg::WORD_W-1:0] i_wd_w;
`ifdef DMEM_RESPONDER_BYTE_EN
  logic [mips_pkg::LANES-1:0]  i_be_w;
`endif
  logic                        o_ready_w;
  logic                        o_rvalid_w;
  logic [mips_pkg::WORD_W-1:0] o_rd_w;
  logic                        o_err_w;
  logic                        o_busy_w;

`ifdef DMEM_RESPONDER_BYTE_EN
  modport master (
    output i_req_w, i_we_w, i_a_w, i_wd_w, i_be_w,
    input  o_ready_w, o_rvalid_w, o_rd_w, o_err_w, o_busy_w
  );
  modport slave (
    input  i_req_w, i_we_w, i_a_w, i_wd_w, i_be_w,
    output o_ready_w, o_rvalid_w, o_rd_w, o_err_w, o_busy_w
  );
`else
  modport master (
    output i_req_w, i_we_w, i_a_w, i_wd_w,
    input  o_ready_w, o_rvalid_w, o_rd_w, o_err_w, o_busy_w
  );
  modport slave (
    input  i_req_w, i_we_w, i_a_w, i_wd_w,
    output o_ready_w, o_rvalid_w, o_rd_w, o_err_w, o_busy_w
  );
`endif

endinterface

// File: rtl/dmem_array.sv
// Word storage split into byte lanes: synchronous lane-masked write and
// combinational read. Contents are never reset.
module dmem_array
  import mips_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wd,
  input  logic [LANES-1:0]  be,
  output logic [WORD_W-1:0] rd
);

  // One narrow array per lane keeps the byte-enable write a plain RAM write.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[addr] <= wd[8*gi +: 8];
      end
    end

    assign rd[8*gi +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// Define DMEM_RESPONDER_BYTE_EN to honour per-lane write enables.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 64
) (
  input logic              i_clk_w,
  input logic              i_rst_w,
  dmem_responder_if.slave  bus
);

  localparam int               AW        = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic               we_reg;
  logic [WORD_W-1:0]  a_reg;
  logic [WORD_W-1:0]  wd_reg;
  logic [LANES-1:0]   be_reg;

  logic [WORD_W-1:0]  rd_reg;
  logic               err_reg;

  logic               accept;
  logic               access;
  logic               acc_from_bus;
  logic               acc_we;
  logic [WORD_W-1:0]  acc_a;
  logic [WORD_W-1:0]  acc_wd;
  logic [LANES-1:0]   acc_be;
  logic               acc_fault;
  logic               mem_we;
  logic [WORD_W-1:0]  mem_rd;
  logic [LANES-1:0]   in_be;

`ifdef DMEM_RESPONDER_BYTE_EN
  assign in_be = bus.i_be_w;
`else
  assign in_be = '1;
`endif

  assign accept = (state_reg == IDLE) && bus.i_req_w;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.i_req_w) begin
          cnt_next   = WAIT_LOAD;
          state_next = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the access shares the accepting edge, so it takes
  // the values being captured on that same edge straight from the bus.
  assign acc_from_bus = (state_reg == IDLE);
  assign acc_we       = acc_from_bus ? bus.i_we_w : we_reg;
  assign acc_a        = acc_from_bus ? bus.i_a_w  : a_reg;
  assign acc_wd       = acc_from_bus ? bus.i_wd_w : wd_reg;
  assign acc_be       = acc_from_bus ? in_be      : be_reg;

  assign access    = !i_rst_w && (state_reg != RESP) && (state_next == RESP);
  assign acc_fault = addr_fault(acc_a, WORD_W'(DEPTH));
  assign mem_we    = access && acc_we && !acc_fault;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (i_clk_w),
    .we   (mem_we),
    .addr (acc_a[AW+1:2]),
    .wd   (acc_wd),
    .be   (acc_be),
    .rd   (mem_rd)
  );

  always_ff @(posedge i_clk_w) begin
    if (i_rst_w) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rd_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (access) begin
        err_reg <= acc_fault;
        rd_reg  <= (acc_we || acc_fault) ? '0 : mem_rd;
      end
    end
  end

  always_ff @(posedge i_clk_w) begin
    if (accept) begin
      we_reg <= bus.i_we_w;
      a_reg  <= bus.i_a_w;
      wd_reg <= bus.i_wd_w;
      be_reg <= in_be;
    end
  end

  assign bus.o_ready_w  = (state_reg == IDLE);
  assign bus.o_busy_w   = (state_reg != IDLE);
  assign bus.o_rvalid_w = (state_reg == RESP);
  assign bus.o_rd_w     = (state_reg == RESP) ? rd_reg : '0;
  assign bus.o_err_w    = (state_reg == RESP) && err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: one instance with two wait states, one
// with none, both checked against a word-array model of the memory.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus2();
  dmem_responder_if bus0();

  dmem_responder #(.WAIT_STATES(2), .DEPTH(DEPTH)) u_dut2 (
    .i_clk_w (clk),
    .i_rst_w (rst),
    .bus     (bus2.slave)
  );

  dmem_responder #(.WAIT_STATES(0), .DEPTH(DEPTH)) u_dut0 (
    .i_clk_w (clk),
    .i_rst_w (rst),
    .bus     (bus0.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] model [2][DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // sel 0 -> two wait states, sel 1 -> zero wait states
  function automatic int ws_of(input int sel);
    return (sel != 0) ? 0 : 2;
  endfunction

  // {ready, busy, rvalid, err}
  function automatic logic [3:0] flags(input int sel);
    if (sel != 0) return {bus0.o_ready_w, bus0.o_busy_w, bus0.o_rvalid_w, bus0.o_err_w};
    return {bus2.o_ready_w, bus2.o_busy_w, bus2.o_rvalid_w, bus2.o_err_w};
  endfunction

  function automatic logic [31:0] rdata(input int sel);
    return (sel != 0) ? bus0.o_rd_w : bus2.o_rd_w;
  endfunction

  task automatic drive(input int sel, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (sel != 0) begin
      bus0.i_req_w = req; bus0.i_we_w = we; bus0.i_a_w = a; bus0.i_wd_w = wd;
`ifdef DMEM_RESPONDER_BYTE_EN
      bus0.i_be_w = be;
`endif
    end else begin
      bus2.i_req_w = req; bus2.i_we_w = we; bus2.i_a_w = a; bus2.i_wd_w = wd;
`ifdef DMEM_RESPONDER_BYTE_EN
      bus2.i_be_w = be;
`endif
    end
  endtask

  // Expected response for a request, applying any write to the model.
  task automatic model_apply(input int sel, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be,
                             output logic [31:0] exp_rd, output logic exp_err);
    logic [3:0]  eff_be;
    logic [31:0] w;
    int          idx;
`ifdef DMEM_RESPONDER_BYTE_EN
    eff_be = be;
`else
    eff_be = 4'hF;
`endif
    exp_err = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    exp_rd  = '0;
    if (!exp_err) begin
      idx = int'(a >> 2);
      if (!we) begin
        exp_rd = model[sel][idx];
      end else begin
        w = model[sel][idx];
        for (int k = 0; k < 4; k++)
          if (eff_be[k]) w[8*k +: 8] = wd[8*k +: 8];
        model[sel][idx] = w;
      end
    end
  endtask

  task automatic txn(input int sel, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [3:0]  f;
    int          ws;
    int          n;
    ws = ws_of(sel);
    model_apply(sel, we, a, wd, be, exp_rd, exp_err);
    got_rd  = '0;
    got_err = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, we, a, wd, be);
    n = 0;
    f = flags(sel);
    while (!f[3] && n < 20) begin
      @(negedge clk);
      f = flags(sel);
      n++;
    end
    if (n >= 20) begin
      chk("accept_timeout", 32'(0), 32'(1));
      drive(sel, 1'b0, 1'b0, '0, '0, '0);
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the inputs once accepted; the in-flight access must not see it.
    drive(sel, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    for (int k = 1; k <= ws + 1; k++) begin
      @(negedge clk);
      f = flags(sel);
      if (k <= ws) begin
        chk("wait_flags", 32'(f), 32'(4'b0100));
        chk("wait_rd", rdata(sel), 32'(0));
      end else begin
        chk("resp_flags", 32'(f), 32'({3'b011, exp_err}));
        chk("resp_rd", rdata(sel), exp_rd);
        got_rd  = rdata(sel);
        got_err = f[0];
      end
    end
    $display("txn dut_ws%0d we=%0d a=%08h wd=%08h rd=%08h err=%0d",
             ws, we, a, wd, got_rd, got_err);
  endtask

  // Request held high across three back-to-back reads of one word.
  task automatic burst(input int sel, input logic [31:0] a);
    int          p;
    logic [3:0]  f;
    logic [3:0]  ef;
    logic [31:0] word;
    p    = ws_of(sel) + 2;
    word = model[sel][int'(a >> 2)];
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, a, '0, 4'hF);
    for (int c = 0; c < 3 * p; c++) begin
      if (c > 0) @(negedge clk);
      f  = flags(sel);
      ef = {(c % p) == 0, (c % p) != 0, (c % p) == p - 1, 1'b0};
      chk("burst_flags", 32'(f), 32'(ef));
      chk("burst_rd", rdata(sel), ((c % p) == p - 1) ? word : 32'(0));
    end
    drive(sel, 1'b0, 1'b0, '0, '0, '0);
    $display("burst dut_ws%0d a=%08h rd=%08h", ws_of(sel), a, word);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [31:0] old;
    logic [31:0] a;
    logic [3:0]  f;
    int          sel;
    int          r;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags_ws2", 32'(flags(0)), 32'(4'b1000));
    chk("reset_flags_ws0", 32'(flags(1)), 32'(4'b1000));
    chk("reset_rd", rdata(0), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_flags", 32'(flags(0)), 32'(4'b1000));

    // Fill both memories so every later read has a known value.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++)
        txn(s, 1'b1, 32'(i * 4), $urandom, 4'hF, rd, err);

    // Write then read back with two wait states.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err);
    chk("write_rd_zero", rd, 32'(0));
    chk("write_err_zero", 32'(err), 32'(0));
    txn(0, 1'b0, 32'h10, '0, 4'hF, rd, err);
    chk("read_deadbeef", rd, 32'hDEADBEEF);

    // Same with no wait states, plus held-request throughput on both.
    txn(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, rd, err);
    txn(1, 1'b0, 32'h10, '0, 4'hF, rd, err);
    chk("read_ws0", rd, 32'hCAFEF00D);
    burst(1, 32'h10);
    burst(0, 32'h10);

    // Faults: misaligned read, out-of-range write, neighbour untouched.
    for (int s = 0; s < 2; s++) begin
      old = model[s][DEPTH-1];
      txn(s, 1'b0, 32'h13, '0, 4'hF, rd, err);
      chk("misaligned_err", 32'(err), 32'(1));
      chk("misaligned_rd", rd, 32'(0));
      txn(s, 1'b1, 32'h100, 32'h5555AAAA, 4'hF, rd, err);
      chk("range_err", 32'(err), 32'(1));
      txn(s, 1'b0, 32'hFC, '0, 4'hF, rd, err);
      chk("fc_unchanged", rd, old);
    end

    // Reset while a write sits in WAIT: abandoned, memory unchanged.
    old = model[0][8];
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    chk("rstw_ready", 32'(flags(0)), 32'(4'b1000));
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("rstw_in_wait", 32'(flags(0)), 32'(4'b0100));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      f = flags(0);
      chk("rstw_no_resp", 32'(f), 32'(4'b1000));
    end
    txn(0, 1'b0, 32'h20, '0, 4'hF, rd, err);
    chk("rstw_prior", rd, old);

    // Lane-enable write.
    txn(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, rd, err);
    txn(1, 1'b1, 32'h20, 32'h11223344, 4'b0101, rd, err);
    txn(1, 1'b0, 32'h20, '0, 4'hF, rd, err);
`ifdef DMEM_RESPONDER_BYTE_EN
    chk("byte_en_merge", rd, 32'hAA22CC44);
`else
    chk("full_word_write", rd, 32'h11223344);
`endif

    // Random mix of reads, writes, faults and bursts on both instances.
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 11));
      if (r < 7)       a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (r == 7) a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      else if (r == 8) a = 32'(DEPTH + $urandom_range(0, 1000)) << 2;
      else             a = $urandom;
      if (r == 11)
        burst(sel, {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00});
      else
        txn(sel, 1'($urandom), a, $urandom, 4'($urandom), rd, err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
